vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Pixel-domain signal bundle between the VGA timing generator and its consumer.
// The generator side takes the pixel clock enable and drives sync, counters and pulses.
interface vga_timing_if #(
  parameter int unsigned CW = 10
);
  logic          ce;
  logic          vga_h_sync;
  logic          vga_v_sync;
  logic          inDisplayArea;
  logic [CW-1:0] CounterX;
  logic [CW-1:0] CounterY;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  ce,
    output vga_h_sync, vga_v_sync, inDisplayArea,
    output CounterX, CounterY, line_start, frame_start
  );

  modport slave (
    output ce,
    input  vga_h_sync, vga_v_sync, inDisplayArea,
    input  CounterX, CounterY, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing: pixel/line counters with registered syncs,
// visible-area flag and one-clock line/frame start pulses, advanced by a pixel enable.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0,
  parameter int unsigned CW        = 10
) (
  input logic        clk,
  input logic        rst,
  vga_timing_if.master vga
);

  localparam int unsigned     H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned     V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam longint unsigned CNT_RANGE = 64'd1 << CW;

  if ((64'(H_TOTAL) > CNT_RANGE) || (64'(V_TOTAL) > CNT_RANGE)) begin : g_range_err
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
  end

  if ((H_VISIBLE == 0) || (H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
      (V_VISIBLE == 0) || (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : g_zero_err
    $error("vga_timing_gen: timing parameters must be non-zero");
  end

  // Decode boundaries; every end value is below H_TOTAL/V_TOTAL, so it fits in CW bits.
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_VIS_END    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0] cnt_x_q, cnt_x_d;
  logic [CW-1:0] cnt_y_q, cnt_y_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          disp_q, disp_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          x_wrap, y_wrap;

  // Next-state: everything holds unless ce; start pulses clear on every edge.
  always_comb begin
    cnt_x_d       = cnt_x_q;
    cnt_y_d       = cnt_y_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    disp_d        = disp_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    x_wrap        = (cnt_x_q == H_LAST);
    y_wrap        = (cnt_y_q == V_LAST);

    if (vga.ce) begin
      cnt_x_d = x_wrap ? '0 : cnt_x_q + CW'(1);
      if (x_wrap) begin
        cnt_y_d = y_wrap ? '0 : cnt_y_q + CW'(1);
      end
      h_sync_d      = ((cnt_x_q >= H_SYNC_START) && (cnt_x_q < H_SYNC_END)) ? H_POL : ~H_POL;
      v_sync_d      = ((cnt_y_q >= V_SYNC_START) && (cnt_y_q < V_SYNC_END)) ? V_POL : ~V_POL;
      disp_d        = (cnt_x_q < H_VIS_END) && (cnt_y_q < V_VIS_END);
      line_start_d  = x_wrap;
      frame_start_d = x_wrap && y_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_x_q       <= '0;
      cnt_y_q       <= '0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      disp_q        <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_x_q       <= cnt_x_d;
      cnt_y_q       <= cnt_y_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      disp_q        <= disp_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.CounterX      = cnt_x_q;
  assign vga.CounterY      = cnt_y_q;
  assign vga.vga_h_sync    = h_sync_q;
  assign vga.vga_v_sync    = v_sync_q;
  assign vga.inDisplayArea = disp_q;
  assign vga.line_start    = line_start_q;
  assign vga.frame_start   = frame_start_q;

endmodule
